// File: rtl/alu_seq_pkg.sv
// Shared opcodes, FSM state encoding and iterative-unit mode for the sequential signed ALU.
package alu_seq_pkg;

  localparam logic [2:0] OP_ADD = 3'b000;
  localparam logic [2:0] OP_SUB = 3'b001;
  localparam logic [2:0] OP_MUL = 3'b010;
  localparam logic [2:0] OP_DIV = 3'b011;
  localparam logic [2:0] OP_NOT = 3'b100;
  localparam logic [2:0] OP_AND = 3'b101;
  localparam logic [2:0] OP_OR  = 3'b110;
  localparam logic [2:0] OP_XOR = 3'b111;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    BUSY = 2'd1,
    FIX  = 2'd2,
    DONE = 2'd3
  } alu_state_e;

  typedef enum logic {
    MODE_MUL = 1'b0,
    MODE_DIV = 1'b1
  } iter_mode_e;

  function automatic logic is_long_op(input logic [2:0] op);
    return (op == OP_MUL) || (op == OP_DIV);
  endfunction

endpackage

// File: rtl/alu_seq_if.sv
// Request/response handshake bundle between decode, the sequential ALU and writeback.
interface alu_seq_if #(parameter int WIDTH = 32);
  logic                      in_valid;
  logic                      in_ready;
  logic [2:0]                op;
  logic signed [WIDTH-1:0]   num1;
  logic signed [WIDTH-1:0]   num2;
  logic                      out_valid;
  logic                      out_ready;
  logic [2*WIDTH-1:0]        res1;
  logic [2*WIDTH-1:0]        res2;
  logic                      ovf;
  logic                      dz;

  modport master (
    output in_valid, op, num1, num2, out_ready,
    input  in_ready, out_valid, res1, res2, ovf, dz
  );

  modport slave (
    input  in_valid, op, num1, num2, out_ready,
    output in_ready, out_valid, res1, res2, ovf, dz
  );
endinterface

// File: rtl/alu_iter_unit.sv
// Iterative unsigned datapath: shift-add multiply or restoring divide on magnitudes,
// one step per clock, WIDTH steps per operation.
module alu_iter_unit
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start_i,
  input  iter_mode_e       mode_i,
  input  logic [WIDTH-1:0] a_i,
  input  logic [WIDTH-1:0] b_i,
  output logic             done_o,
  output logic [WIDTH-1:0] hi_o,
  output logic [WIDTH-1:0] lo_o
);

  localparam int CNT_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(WIDTH - 1);

  logic             busy_q, busy_d;
  iter_mode_e       mode_q, mode_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] acc_q, acc_d;
  logic [WIDTH-1:0] sh_q, sh_d;
  logic [WIDTH-1:0] b_q, b_d;

  logic [WIDTH-1:0] mul_addend;
  logic [WIDTH:0]   mul_sum;
  logic [WIDTH:0]   div_shift;
  logic [WIDTH-1:0] div_diff;
  logic             div_ok;

  // mul: {acc, sh} is the product register, multiplier bits shift out of sh.
  // div: sh holds the dividend shifting out and collects quotient bits; acc is the remainder.
  always_comb begin
    mul_addend = sh_q[0] ? b_q : '0;
    mul_sum    = {1'b0, acc_q} + {1'b0, mul_addend};
    div_shift  = {acc_q, sh_q[WIDTH-1]};
    div_ok     = div_shift >= {1'b0, b_q};
    div_diff   = div_shift[WIDTH-1:0] - b_q;

    busy_d = busy_q;
    mode_d = mode_q;
    cnt_d  = cnt_q;
    acc_d  = acc_q;
    sh_d   = sh_q;
    b_d    = b_q;

    if (start_i) begin
      busy_d = 1'b1;
      mode_d = mode_i;
      cnt_d  = '0;
      acc_d  = '0;
      sh_d   = a_i;
      b_d    = b_i;
    end else if (busy_q) begin
      if (mode_q == MODE_MUL) begin
        acc_d = mul_sum[WIDTH:1];
        sh_d  = {mul_sum[0], sh_q[WIDTH-1:1]};
      end else begin
        acc_d = div_ok ? div_diff : div_shift[WIDTH-1:0];
        sh_d  = {sh_q[WIDTH-2:0], div_ok};
      end
      if (cnt_q == CNT_LAST) begin
        busy_d = 1'b0;
        cnt_d  = '0;
      end else begin
        cnt_d = cnt_q + CNT_W'(1);
      end
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_q <= 1'b0;
      mode_q <= MODE_MUL;
      cnt_q  <= '0;
      acc_q  <= '0;
      sh_q   <= '0;
      b_q    <= '0;
    end else begin
      busy_q <= busy_d;
      mode_q <= mode_d;
      cnt_q  <= cnt_d;
      acc_q  <= acc_d;
      sh_q   <= sh_d;
      b_q    <= b_d;
    end
  end

  assign done_o = busy_q && (cnt_q == CNT_LAST);
  assign hi_o   = acc_q;
  assign lo_o   = sh_q;

endmodule

// File: rtl/alu_seq.sv
// Sequential signed ALU: handshake FSM, single-cycle ops and sign handling around
// the iterative multiply/divide unit.
module alu_seq
  import alu_seq_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input  logic     clk,
  input  logic     rst_n,
  alu_seq_if.slave bus
);

  localparam logic [WIDTH-1:0] SMIN = {1'b1, {(WIDTH-1){1'b0}}};

  alu_state_e         state_q, state_d;
  logic [2:0]         op_q, op_d;
  logic               neg_q, neg_d;
  logic               rem_neg_q, rem_neg_d;
  logic               spec_q, spec_d;
  logic [2*WIDTH-1:0] res1_q, res1_d;
  logic [2*WIDTH-1:0] res2_q, res2_d;
  logic               ovf_q, ovf_d;
  logic               dz_q, dz_d;

  logic               accept;
  logic               sign1, sign2;
  logic [WIDTH-1:0]   mag1, mag2;
  logic               iter_start;
  iter_mode_e         iter_mode;
  logic               iter_done;
  logic [WIDTH-1:0]   iter_hi, iter_lo;
  logic [WIDTH-1:0]   sum_w, diff_w;
  logic [2*WIDTH-1:0] prod_u, quot_u, rem_u;

  function automatic logic [2*WIDTH-1:0] sext(input logic [WIDTH-1:0] v);
    return {{WIDTH{v[WIDTH-1]}}, v};
  endfunction

  assign accept     = bus.in_valid && (state_q == IDLE);
  assign sign1      = bus.num1[WIDTH-1];
  assign sign2      = bus.num2[WIDTH-1];
  assign mag1       = sign1 ? -bus.num1 : bus.num1;
  assign mag2       = sign2 ? -bus.num2 : bus.num2;
  assign iter_mode  = (bus.op == OP_DIV) ? MODE_DIV : MODE_MUL;
  assign iter_start = accept && is_long_op(bus.op) &&
                      !((bus.op == OP_DIV) && (bus.num2 == '0));

  alu_iter_unit #(.WIDTH(WIDTH)) u_iter (
    .clk    (clk),
    .rst_n  (rst_n),
    .start_i(iter_start),
    .mode_i (iter_mode),
    .a_i    (mag1),
    .b_i    (mag2),
    .done_o (iter_done),
    .hi_o   (iter_hi),
    .lo_o   (iter_lo)
  );

  always_comb begin
    sum_w  = bus.num1 + bus.num2;
    diff_w = bus.num1 - bus.num2;
    prod_u = {iter_hi, iter_lo};
    quot_u = {{WIDTH{1'b0}}, iter_lo};
    rem_u  = {{WIDTH{1'b0}}, iter_hi};

    state_d   = state_q;
    op_d      = op_q;
    neg_d     = neg_q;
    rem_neg_d = rem_neg_q;
    spec_d    = spec_q;
    res1_d    = res1_q;
    res2_d    = res2_q;
    ovf_d     = ovf_q;
    dz_d      = dz_q;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          op_d      = bus.op;
          neg_d     = sign1 ^ sign2;
          rem_neg_d = sign1;
          spec_d    = (bus.num1 == SMIN) && (bus.num2 == '1);
          state_d   = DONE;
          res2_d    = '0;
          ovf_d     = 1'b0;
          dz_d      = 1'b0;
          case (bus.op)
            OP_ADD: begin
              res1_d = sext(sum_w);
              ovf_d  = (sign1 == sign2) && (sum_w[WIDTH-1] != sign1);
            end
            OP_SUB: begin
              res1_d = sext(diff_w);
              ovf_d  = (sign1 != sign2) && (diff_w[WIDTH-1] != sign1);
            end
            OP_MUL: state_d = BUSY;
            OP_DIV: begin
              if (bus.num2 == '0) begin
                res1_d = '0;
                res2_d = sext(bus.num1);
                dz_d   = 1'b1;
              end else begin
                state_d = BUSY;
              end
            end
            OP_NOT:  res1_d = sext(~bus.num1);
            OP_AND:  res1_d = sext(bus.num1 & bus.num2);
            OP_OR:   res1_d = sext(bus.num1 | bus.num2);
            default: res1_d = sext(bus.num1 ^ bus.num2);
          endcase
        end
      end
      BUSY: begin
        if (iter_done) state_d = FIX;
      end
      FIX: begin
        state_d = DONE;
        dz_d    = 1'b0;
        if (op_q == OP_MUL) begin
          res1_d = neg_q ? -prod_u : prod_u;
          res2_d = '0;
          ovf_d  = 1'b0;
        end else begin
          // the MIN/-1 quotient magnitude is representable in 2*WIDTH, only flagged
          res1_d = neg_q ? -quot_u : quot_u;
          res2_d = rem_neg_q ? -rem_u : rem_u;
          ovf_d  = spec_q;
        end
      end
      default: begin
        if (bus.out_ready) state_d = IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q   <= IDLE;
      op_q      <= OP_ADD;
      neg_q     <= 1'b0;
      rem_neg_q <= 1'b0;
      spec_q    <= 1'b0;
      res1_q    <= '0;
      res2_q    <= '0;
      ovf_q     <= 1'b0;
      dz_q      <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      neg_q     <= neg_d;
      rem_neg_q <= rem_neg_d;
      spec_q    <= spec_d;
      res1_q    <= res1_d;
      res2_q    <= res2_d;
      ovf_q     <= ovf_d;
      dz_q      <= dz_d;
    end
  end

  assign bus.in_ready  = (state_q == IDLE);
  assign bus.out_valid = (state_q == DONE);
  assign bus.res1      = res1_q;
  assign bus.res2      = res2_q;
  assign bus.ovf       = ovf_q;
  assign bus.dz        = dz_q;

endmodule

// File: tb/tb_alu_seq.sv
// Randomized self-checking bench for alu_seq at WIDTH=8 against an integer-arithmetic model.
module tb_alu_seq;
  import alu_seq_pkg::*;

  localparam int W = 8;

  logic clk = 1'b0;
  logic rst_n;
  int   n_checks = 0;
  int   n_errors = 0;

  always #5 clk = ~clk;

  alu_seq_if #(.WIDTH(W)) bus ();

  alu_seq #(.WIDTH(W)) dut (
    .clk  (clk),
    .rst_n(rst_n),
    .bus  (bus)
  );

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
    end
  endtask

  task automatic ref_model(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                           output logic [15:0] e1, output logic [15:0] e2,
                           output logic eo, output logic ed, output int lat);
    int a, b, r;
    logic [7:0] t;
    bit wide;
    a = int'($signed(x));
    b = int'($signed(y));
    r = 0; e2 = '0; eo = 1'b0; ed = 1'b0; lat = 1; wide = 1'b0;
    case (op)
      OP_ADD: begin r = a + b; eo = (r > 127) || (r < -128); end
      OP_SUB: begin r = a - b; eo = (r > 127) || (r < -128); end
      OP_MUL: begin r = a * b; wide = 1'b1; lat = W + 2; end
      OP_DIV: begin
        wide = 1'b1;
        if (b == 0) begin
          ed = 1'b1; r = 0; e2 = 16'(a);
        end else if (a == -128 && b == -1) begin
          r = 128; eo = 1'b1; lat = W + 2;
        end else begin
          r = a / b; e2 = 16'(a % b); lat = W + 2;
        end
      end
      OP_NOT: r = ~a;
      OP_AND: r = a & b;
      OP_OR:  r = a | b;
      default: r = a ^ b;
    endcase
    t  = 8'(r);
    e1 = wide ? 16'(r) : {{8{t[7]}}, t};
  endtask

  task automatic run_op(input logic [2:0] op, input logic [7:0] x, input logic [7:0] y,
                        input int hold, input string tag);
    logic [15:0] e1, e2;
    logic eo, ed;
    int lat_exp, lat;
    bit rdy_bad, unstable;
    ref_model(op, x, y, e1, e2, eo, ed, lat_exp);
    @(negedge clk);
    for (int i = 0; i < 20 && !bus.in_ready; i++) @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = op;
    bus.num1     = x;
    bus.num2     = y;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    bus.num1     = 8'($urandom);
    bus.num2     = 8'($urandom);
    bus.op       = 3'($urandom);
    lat = 0;
    rdy_bad = 1'b0;
    for (int k = 1; k <= 40; k++) begin
      @(negedge clk);
      if (bus.out_valid) begin
        lat = k;
        break;
      end
      if (bus.in_ready) rdy_bad = 1'b1;
    end
    check({tag, "_lat"}, 64'(lat), 64'(lat_exp));
    if (lat_exp > 1) check({tag, "_rdy_busy"}, 64'(rdy_bad), 64'd0);
    check({tag, "_res1"}, 64'(bus.res1), 64'(e1));
    check({tag, "_res2"}, 64'(bus.res2), 64'(e2));
    check({tag, "_ovf"}, 64'(bus.ovf), 64'(eo));
    check({tag, "_dz"}, 64'(bus.dz), 64'(ed));
    check({tag, "_rdy_done"}, 64'(bus.in_ready), 64'd0);
    if (hold > 0) begin
      unstable = 1'b0;
      repeat (hold) begin
        @(negedge clk);
        if (bus.res1 !== e1 || bus.res2 !== e2 || bus.ovf !== eo || bus.dz !== ed ||
            bus.out_valid !== 1'b1 || bus.in_ready !== 1'b0)
          unstable = 1'b1;
      end
      check({tag, "_hold"}, 64'(unstable), 64'd0);
    end
    bus.out_ready = 1'b1;
    @(posedge clk);
    #1;
    check({tag, "_post_vld"}, 64'(bus.out_valid), 64'd0);
    check({tag, "_post_rdy"}, 64'(bus.in_ready), 64'd1);
    bus.out_ready = 1'b0;
  endtask

  initial begin
    #1000000;
    $display("FAIL watchdog timeout");
    $fatal(1, "watchdog");
  end

  initial begin
    logic [2:0] rop;
    logic [7:0] rx, ry;
    bus.in_valid  = 1'b0;
    bus.op        = OP_ADD;
    bus.num1      = '0;
    bus.num2      = '0;
    bus.out_ready = 1'b0;
    rst_n         = 1'b0;
    #12;
    check("rst_in_ready", 64'(bus.in_ready), 64'd1);
    check("rst_out_valid", 64'(bus.out_valid), 64'd0);
    check("rst_res1", 64'(bus.res1), 64'd0);
    check("rst_res2", 64'(bus.res2), 64'd0);
    check("rst_ovf", 64'(bus.ovf), 64'd0);
    check("rst_dz", 64'(bus.dz), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    run_op(OP_ADD, 8'd100, 8'd50, 0, "add_ovf");
    run_op(OP_MUL, 8'hF9, 8'd9, 0, "mul_neg");
    run_op(OP_DIV, 8'hF9, 8'd2, 0, "div_neg");
    run_op(OP_DIV, 8'd5, 8'd0, 0, "div_zero");
    run_op(OP_DIV, 8'h80, 8'hFF, 0, "div_min");
    run_op(OP_XOR, 8'hF0, 8'h3C, 5, "xor_hold");
    run_op(OP_SUB, 8'h80, 8'd1, 0, "sub_ovf");
    run_op(OP_MUL, 8'h80, 8'h80, 0, "mul_minmin");
    run_op(OP_MUL, 8'h80, 8'hFF, 0, "mul_min_m1");
    run_op(OP_DIV, 8'd7, 8'hFE, 0, "div_posneg");
    run_op(OP_NOT, 8'h0F, 8'h00, 2, "not");

    // abort a multiply mid-iteration
    @(negedge clk);
    bus.in_valid = 1'b1;
    bus.op       = OP_MUL;
    bus.num1     = 8'h85;
    bus.num2     = 8'h77;
    @(posedge clk);
    #1;
    bus.in_valid = 1'b0;
    repeat (5) @(negedge clk);
    rst_n = 1'b0;
    #1;
    check("abort_out_valid", 64'(bus.out_valid), 64'd0);
    check("abort_in_ready", 64'(bus.in_ready), 64'd1);
    check("abort_res1", 64'(bus.res1), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;
    run_op(OP_ADD, 8'd1, 8'd1, 0, "add_after_rst");

    for (int n = 0; n < 60; n++) begin
      rop = 3'($urandom_range(0, 7));
      rx  = 8'($urandom);
      ry  = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom);
      if ($urandom_range(0, 9) == 0) rx = 8'h80;
      run_op(rop, rx, ry, $urandom_range(0, 2), $sformatf("rnd%0d_op%0d", n, rop));
    end

    $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
    $finish;
  end

endmodule
